// File: rtl/snd_mixer_pkg.sv
// snd_mixer_pkg
// Shared types and helpers for the snd_mixer_tdm stereo mixer.
//   state_t     : mix-pass FSM states (ST_DCB is only reachable when
//                 SND_MIXER_DC_BLOCK_EN is defined)
//   vol_to_gain : 4-bit two's complement volume code -> 6-bit gain in 1/16 units
//   acc_width   : accumulator width for IW-bit samples summed over CH channels
//   sat         : clamp a signed value to the range of an OW-bit signed number
package snd_mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_DCB  = 2'd3
  } state_t;

  // g = 16 + 2*vol = 2*(vol + 8). Adding 8 to a 4-bit two's complement code
  // is the same as flipping its sign bit, so no adder is needed.
  function automatic logic [5:0] vol_to_gain(input logic [3:0] vol);
    return {1'b0, ~vol[3], vol[2:0], 1'b0};
  endfunction

  // Product needs IW+5 bits (gain < 32); summing up to CH of them adds
  // clog2(CH+1) bits, so the accumulator cannot overflow.
  function automatic int acc_width(input int iw, input int ch);
    return iw + 5 + $clog2(ch + 1);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] acc,
                                             input int                ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/snd_dc_block.sv
// snd_dc_block
// One-pole DC-blocking high-pass for one stereo side, built only when
// SND_MIXER_DC_BLOCK_EN is defined:
//   y = x - x_prev + y_prev - (y_prev >>> 8), saturated to OW bits.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset, clears x_prev / y_prev
//   i_en   : process i_x this cycle
//   i_x    : OW-bit signed input sample
//   o_y    : OW-bit signed filtered sample (registered)
`ifdef SND_MIXER_DC_BLOCK_EN
module snd_dc_block
  import snd_mixer_pkg::*;
#(
  parameter int OW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic signed [OW-1:0] i_x,
  output logic signed [OW-1:0] o_y
);

  // Difference of two OW-bit values plus a third needs OW+2 bits; one
  // spare bit keeps the intermediate comfortably wide.
  localparam int DW = OW + 3;

  logic signed [OW-1:0] r_x_prev;
  logic signed [OW-1:0] r_y_prev;
  logic signed [DW-1:0] w_sum;
  logic signed [OW-1:0] w_y;

  assign w_sum = DW'(i_x) - DW'(r_x_prev) + DW'(r_y_prev) - DW'(r_y_prev >>> 8);
  assign w_y   = OW'(sat(64'(w_sum), OW));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
    end else if (i_en) begin
      r_x_prev <= i_x;
      r_y_prev <= w_y;
    end
  end

  assign o_y = r_y_prev;

endmodule
`endif

// File: rtl/snd_mixer_tdm.sv
// snd_mixer_tdm
// Time-multiplexed stereo mixer: one multiplier visits one channel per clock,
// scaling each snapshotted sample by its volume gain and adding it to the
// left and/or right accumulator according to its pan bits. The sums are
// divided by 16 (floor) and saturated to OW bits.
// Optional feature: define SND_MIXER_DC_BLOCK_EN to add a DC-blocking
// high-pass stage (one extra cycle of latency) after saturation.
// Ports:
//   i_EMU_MCLK    : clock, rising edge
//   i_EMU_SOFTRST : synchronous active-high reset
//   i_SND_STB     : one-cycle strobe, starts a mix pass when idle
//   i_SND_CH      : CH packed signed IW-bit samples
//   i_VOL         : CH packed 4-bit volume codes (-8 mutes, 0 is unity)
//   i_PAN         : CH packed pan pairs, bit0 = left, bit1 = right
//   o_SND_L/R     : mixed signed OW-bit samples, held between updates
//   o_SND_VLD     : one-cycle pulse when o_SND_L/R update
//   o_BUSY        : high while a pass runs, through the o_SND_VLD cycle
//   o_DROP        : one-cycle pulse after a strobe that arrived while busy
module snd_mixer_tdm
  import snd_mixer_pkg::*;
#(
  parameter int CH = 4,
  parameter int IW = 16,
  parameter int OW = 16
) (
  input  logic                 i_EMU_MCLK,
  input  logic                 i_EMU_SOFTRST,
  input  logic                 i_SND_STB,
  input  logic [CH*IW-1:0]     i_SND_CH,
  input  logic [CH*4-1:0]      i_VOL,
  input  logic [CH*2-1:0]      i_PAN,
  output logic signed [OW-1:0] o_SND_L,
  output logic signed [OW-1:0] o_SND_R,
  output logic                 o_SND_VLD,
  output logic                 o_BUSY,
  output logic                 o_DROP
);

  localparam int              AW       = acc_width(IW, CH);
  localparam int              IDXW     = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDXW-1:0]      r_idx;
  logic [CH*IW-1:0]     r_snap_ch;
  logic [CH*4-1:0]      r_snap_vol;
  logic [CH*2-1:0]      r_snap_pan;
  logic signed [AW-1:0] r_acc_l;
  logic signed [AW-1:0] r_acc_r;
  logic signed [OW-1:0] r_mix_l;
  logic signed [OW-1:0] r_mix_r;
  logic                 r_vld;
  logic                 r_drop;

  logic                 w_busy;
  logic                 w_start;
  logic                 w_last;
  logic signed [IW-1:0] w_sample;
  logic [5:0]           w_gain;
  logic [1:0]           w_pan;
  logic signed [AW-1:0] w_prod;
  logic signed [AW-1:0] w_shr_l;
  logic signed [AW-1:0] w_shr_r;
  logic signed [OW-1:0] w_sat_l;
  logic signed [OW-1:0] w_sat_r;

  // Busy stays up through the output-valid cycle, so a strobe there is a drop.
  assign w_busy  = (r_state != ST_IDLE) || r_vld;
  assign w_start = i_SND_STB && !w_busy;
  assign w_last  = (r_idx == LAST_IDX);

  // Shared multiplier: signed sample times unsigned gain (zero-extended).
  assign w_sample = r_snap_ch[r_idx*IW +: IW];
  assign w_gain   = vol_to_gain(r_snap_vol[r_idx*4 +: 4]);
  assign w_pan    = r_snap_pan[r_idx*2 +: 2];
  assign w_prod   = AW'(w_sample) * AW'(signed'({1'b0, w_gain}));

  // Gain is in 1/16 units; arithmetic shift gives floor rounding.
  assign w_shr_l = r_acc_l >>> 4;
  assign w_shr_r = r_acc_r >>> 4;
  assign w_sat_l = OW'(sat(64'(w_shr_l), OW));
  assign w_sat_r = OW'(sat(64'(w_shr_r), OW));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_SOFTRST) r_state <= ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first guarantees no latch is inferred for
  // any path through the case statement.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_ACC;
      ST_ACC:  if (w_last)  w_state_nxt = ST_SAT;
`ifdef SND_MIXER_DC_BLOCK_EN
      ST_SAT:  w_state_nxt = ST_DCB;
`else
      ST_SAT:  w_state_nxt = ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the snapshot registers carry no reset; they are always written
  // before use, so clearing them would only cost reset fan-out.
  always_ff @(posedge i_EMU_MCLK) begin
    if (w_start) begin
      r_snap_ch  <= i_SND_CH;
      r_snap_vol <= i_VOL;
      r_snap_pan <= i_PAN;
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_SOFTRST) begin
      r_idx   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_mix_l <= '0;
      r_mix_r <= '0;
      r_vld   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_drop <= i_SND_STB && w_busy;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_idx   <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
          end
        end
        ST_ACC: begin
          if (w_pan[0]) r_acc_l <= r_acc_l + w_prod;
          if (w_pan[1]) r_acc_r <= r_acc_r + w_prod;
          r_idx <= r_idx + 1'b1;
        end
        ST_SAT: begin
          r_mix_l <= w_sat_l;
          r_mix_r <= w_sat_r;
`ifndef SND_MIXER_DC_BLOCK_EN
          r_vld   <= 1'b1;
`endif
        end
        default: begin
`ifdef SND_MIXER_DC_BLOCK_EN
          r_vld <= 1'b1;
`endif
        end
      endcase
    end
  end

`ifdef SND_MIXER_DC_BLOCK_EN
  logic w_dc_en;
  assign w_dc_en = (r_state == ST_DCB);

  snd_dc_block #(.OW(OW)) u_dc_l (
    .i_clk (i_EMU_MCLK),
    .i_rst (i_EMU_SOFTRST),
    .i_en  (w_dc_en),
    .i_x   (r_mix_l),
    .o_y   (o_SND_L)
  );

  snd_dc_block #(.OW(OW)) u_dc_r (
    .i_clk (i_EMU_MCLK),
    .i_rst (i_EMU_SOFTRST),
    .i_en  (w_dc_en),
    .i_x   (r_mix_r),
    .o_y   (o_SND_R)
  );
`else
  assign o_SND_L = r_mix_l;
  assign o_SND_R = r_mix_r;
`endif

  assign o_SND_VLD = r_vld;
  assign o_BUSY    = w_busy;
  assign o_DROP    = r_drop;

endmodule

// File: tb/tb_snd_mixer_tdm.sv
// tb_snd_mixer_tdm
// Self-checking bench for snd_mixer_tdm (default build, CH=4, IW=OW=16).
// Expected outputs come from an arithmetic model of the mixing rules:
// sum of sample*gain per side, floor-divide by 16, clamp to 16 bits.
module tb_snd_mixer_tdm;

  localparam int CH = 4;
  localparam int IW = 16;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stb;
  logic [CH*IW-1:0]     snd_ch;
  logic [CH*4-1:0]      vol_bus;
  logic [CH*2-1:0]      pan_bus;
  logic signed [OW-1:0] snd_l;
  logic signed [OW-1:0] snd_r;
  logic                 vld;
  logic                 busy;
  logic                 drop;

  always #5 clk = ~clk;

  snd_mixer_tdm #(.CH(CH), .IW(IW), .OW(OW)) dut (
    .i_EMU_MCLK    (clk),
    .i_EMU_SOFTRST (rst),
    .i_SND_STB     (stb),
    .i_SND_CH      (snd_ch),
    .i_VOL         (vol_bus),
    .i_PAN         (pan_bus),
    .o_SND_L       (snd_l),
    .o_SND_R       (snd_r),
    .o_SND_VLD     (vld),
    .o_BUSY        (busy),
    .o_DROP        (drop)
  );

  int n_checks = 0;
  int n_errors = 0;
  int vld_cnt  = 0;
  int drop_cnt = 0;

  // Reference stimulus for the next pass: sample, volume (-8..7), pan (0..3).
  int smp [CH];
  int vol [CH];
  int pan [CH];

  always @(posedge clk) begin
    #1;
    if (vld === 1'b1)  vld_cnt++;
    if (drop === 1'b1) drop_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  function automatic longint floor16(input longint v);
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // side 0 = left, side 1 = right
  function automatic longint model_side(input int side);
    longint sum = 0;
    for (int n = 0; n < CH; n++)
      if (((pan[n] >> side) & 1) == 1)
        sum += longint'(smp[n]) * longint'(16 + 2 * vol[n]);
    return clamp16(floor16(sum));
  endfunction

  task automatic drive_inputs();
    for (int n = 0; n < CH; n++) begin
      snd_ch[n*IW +: IW] = smp[n][IW-1:0];
      vol_bus[n*4 +: 4]  = vol[n][3:0];
      pan_bus[n*2 +: 2]  = pan[n][1:0];
    end
  endtask

  task automatic scramble_inputs();
    snd_ch  = {$urandom, $urandom};
    vol_bus = 16'($urandom);
    pan_bus = 8'($urandom);
  endtask

  // Ends at the negedge right after the strobe edge; inputs are then
  // scrambled so any use of live inputs instead of the snapshot shows up.
  task automatic strobe();
    @(negedge clk);
    drive_inputs();
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    scramble_inputs();
  endtask

  task automatic randomize_pass();
    for (int n = 0; n < CH; n++) begin
      case ($urandom_range(0, 3))
        0:       smp[n] = 32767;
        1:       smp[n] = -32768;
        default: smp[n] = int'($urandom_range(0, 65535)) - 32768;
      endcase
      vol[n] = int'($urandom_range(0, 15)) - 8;
      pan[n] = int'($urandom_range(0, 3));
    end
  endtask

  task automatic mute_all();
    for (int n = 0; n < CH; n++) begin
      smp[n] = int'($urandom_range(0, 65535)) - 32768;
      vol[n] = -8;
      pan[n] = 3;
    end
  endtask

  task automatic run_pass(input string tag);
    longint exp_l;
    longint exp_r;
    int     lat;
    int     v0;
    int     d0;
    exp_l = model_side(0);
    exp_r = model_side(1);
    v0    = vld_cnt;
    d0    = drop_cnt;
    lat   = 0;
    strobe();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check({tag, "_busy_acc"}, busy, 1);
      if (vld === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, CH + 1);
    if (lat != 0) begin
      check({tag, "_L"}, snd_l, exp_l);
      check({tag, "_R"}, snd_r, exp_r);
      check({tag, "_busy_vld"}, busy, 1);
      @(posedge clk);
      #1;
      check({tag, "_vld_width"}, vld, 0);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_L_hold"}, snd_l, exp_l);
    end
    @(negedge clk);
    check({tag, "_vld_count"}, vld_cnt - v0, 1);
    check({tag, "_drop_count"}, drop_cnt - d0, 0);
  endtask

  initial begin
    longint exp_l;
    longint exp_r;
    int     v0;
    int     d0;

    rst = 1'b1;
    stb = 1'b0;
    snd_ch  = '0;
    vol_bus = '0;
    pan_bus = '0;
    repeat (3) @(negedge clk);
    check("rst_L", snd_l, 0);
    check("rst_R", snd_r, 0);
    check("rst_vld", vld, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unity gain on channel 0, everything else muted.
    mute_all();
    smp[0] = 1000; vol[0] = 0; pan[0] = 3;
    run_pass("unity");
    check("unity_L_const", snd_l, 1000);
    check("unity_R_const", snd_r, 1000);

    // Floor rounding in both directions.
    mute_all();
    smp[0] = 7; vol[0] = 1;
    run_pass("floor_pos");
    check("floor_pos_const", snd_l, 7);
    smp[0] = -7;
    run_pass("floor_neg");
    check("floor_neg_const", snd_r, -8);

    // Saturation at both rails.
    for (int n = 0; n < CH; n++) begin
      smp[n] = 32767; vol[n] = 7; pan[n] = 3;
    end
    run_pass("sat_pos");
    check("sat_pos_const", snd_l, 32767);
    for (int n = 0; n < CH; n++) smp[n] = -32768;
    run_pass("sat_neg");
    check("sat_neg_const", snd_r, -32768);

    // Left-only pan and a muted channel.
    mute_all();
    smp[1] = -2000; vol[1] = 0; pan[1] = 1;
    smp[2] = 5000;  vol[2] = -8; pan[2] = 3;
    run_pass("pan_mute");
    check("pan_mute_L_const", snd_l, -2000);
    check("pan_mute_R_const", snd_r, 0);

    // Strobe two cycles into a pass: dropped, first snapshot wins.
    randomize_pass();
    exp_l = model_side(0);
    exp_r = model_side(1);
    v0 = vld_cnt;
    d0 = drop_cnt;
    strobe();
    @(negedge clk);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_stb_drop", drop_cnt - d0, 1);
    check("busy_stb_vld", vld_cnt - v0, 1);
    check("busy_stb_L", snd_l, exp_l);
    check("busy_stb_R", snd_r, exp_r);

    // Strobe sampled on the saturate edge: still busy, dropped.
    randomize_pass();
    exp_l = model_side(0);
    v0 = vld_cnt;
    d0 = drop_cnt;
    strobe();
    repeat (CH) @(negedge clk);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    repeat (12) @(negedge clk);
    check("sat_stb_drop", drop_cnt - d0, 1);
    check("sat_stb_vld", vld_cnt - v0, 1);
    check("sat_stb_L", snd_l, exp_l);

    // Reset in the middle of a pass, with non-zero outputs beforehand.
    mute_all();
    smp[0] = 1234; vol[0] = 0; pan[0] = 3;
    run_pass("pre_rst");
    randomize_pass();
    v0 = vld_cnt;
    strobe();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_L", snd_l, 0);
    check("midrst_R", snd_r, 0);
    check("midrst_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("midrst_no_vld", vld_cnt - v0, 0);
    check("midrst_L_stays", snd_l, 0);
    run_pass("post_rst");

    // Randomized passes against the model.
    repeat (40) begin
      randomize_pass();
      run_pass("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/snd_mixer_tdm.md
# snd_mixer_tdm

Parametrised, time-multiplexed stereo audio mixer for arcade cores: sums CH signed sound-chip channels into one L/R pair, with per-channel 4-bit volume offsets and per-channel pan enables. It replaces fixed per-chip volume wiring between the sound chips and the AUDIO_L/AUDIO_R outputs. One multiplier serves all channels, one channel per clock.

## Interface
- CH, 4: number of input channels (1..16)
- IW, 16: input sample width, signed
- OW, 16: output sample width, signed; OW ≤ IW+5
- i_EMU_MCLK  in  1  system clock; all logic on rising edge
- i_EMU_SOFTRST  in  1  reset, synchronous, active-high
- i_SND_STB  in  1  one-cycle sample strobe; starts a mix pass
- i_SND_CH  in  CH*IW  packed signed samples; channel n at [n*IW +: IW]
- i_VOL  in  CH*4  packed volume codes, two's complement -8..+7; channel n at [n*4 +: 4]
- i_PAN  in  CH*2  per channel: bit 0 = feed left, bit 1 = feed right
- o_SND_L  out  OW  mixed left sample, signed
- o_SND_R  out  OW  mixed right sample, signed
- o_SND_VLD  out  1  one-cycle pulse when o_SND_L/R update
- o_BUSY  out  1  high while a mix pass runs
- o_DROP  out  1  one-cycle pulse when a strobe arrives while busy

## Operation
- Gain per channel: g = 16 + 2*vol, giving 0..30 in 1/16 units. vol = 0 gives unity; vol = -8 mutes.
- States: IDLE, ACC, SAT (DC stage adds DCB).
- IDLE: on i_SND_STB, snapshot i_SND_CH, i_VOL and i_PAN into registers. Clear both accumulators, set idx = 0, go to ACC.
- ACC: compute p = sample[idx] * g[idx] (signed IW by unsigned 6-bit).
  - Add p to accL if pan[idx][0] is set.
  - Add p to accR if pan[idx][1] is set.
  - Increment idx. After idx = CH-1, go to SAT.
- Accumulator width: IW + 5 + clog2(CH+1) bits, signed. It can never overflow.
- SAT: compute acc >>> 4 (arithmetic shift, floor rounding), then clamp to [-2^(OW-1), 2^(OW-1)-1].
  - Register the results into o_SND_L/R and pulse o_SND_VLD.
  - Return to IDLE.
- Inputs that change during a pass do not affect that pass, because the snapshot is used.
- Strobe while o_BUSY is high: ignored, o_DROP pulses, and the current pass continues unchanged.
- Strobe in the same cycle that SAT returns to IDLE: o_BUSY is still high in that cycle, so it counts as a drop.
- Reset at any time, including mid-pass:
  - State returns to IDLE; idx and accumulators clear.
  - o_SND_L = o_SND_R = 0, o_SND_VLD = 0, o_BUSY = 0, o_DROP = 0.
  - No o_SND_VLD pulse is produced for the aborted pass.

## Timing
- Strobe sampled at edge E0.
- ACC occupies edges E1..ECH.
- SAT registers outputs at edge ECH+1. o_SND_VLD is high for the single cycle after that edge.
- Latency is CH+1 edges (CH+2 with the DC stage). For CH=4: outputs visible 5 cycles after the strobe edge.
- o_BUSY is high from E0+1 until the cycle o_SND_VLD is high, inclusive.
- Minimum strobe spacing: CH+2 cycles (CH+3 with the DC stage).
- o_SND_L/R hold their value between pulses.

## Configuration
- SND_MIXER_DC_BLOCK_EN defined:
  - Adds state DCB after SAT, applying a per-side one-pole high-pass: y = x - x_prev + y_prev - (y_prev >>> 8).
  - The result is saturated to OW bits.
  - x_prev and y_prev clear on reset.
  - Adds 1 cycle of latency.
- SND_MIXER_DC_BLOCK_EN undefined: the DCB state and its registers do not exist; the SAT output drives the ports directly.

## Structure
- Package snd_mixer_pkg holds:
  - the state enum (IDLE, ACC, SAT, DCB);
  - function vol_to_gain(4-bit) returning 6 bits;
  - function acc_width(IW, CH);
  - function sat(acc, OW).
- Sub-module snd_dc_block: one instance per side, present only under SND_MIXER_DC_BLOCK_EN. It has an enable input and a registered output.
- The top holds the snapshot registers, FSM, multiplier, accumulators and output registers.

## Test plan
- Unity: CH=4, ch0=1000, vol0=0, pan0=2'b11, other channels vol=-8. Strobe → after 5 cycles L=R=1000, o_SND_VLD high for 1 cycle.
- Floor rounding: ch0=7, vol=+1 (g=18) → 126>>>4 = 7. ch0=-7 → -126>>>4 = -8.
- Saturation: all 4 channels = 32767, vol=+7 → L=R=32767. All channels = -32768 → L=R=-32768.
- Pan and mute: ch1=-2000, pan1=2'b01; ch2=5000, vol2=-8 → L=-2000, R=0.
- Busy strobe: second strobe 2 cycles after the first → o_DROP pulses once, exactly one o_SND_VLD, outputs from the first snapshot.
- Reset mid-pass: assert i_EMU_SOFTRST at ACC idx=2 → outputs 0, o_BUSY=0, no o_SND_VLD. The next strobe mixes normally.
